// File: rtl/port_rd_frontend.sv
// port_rd_frontend
// Egress replay frontend. Packet words streamed from the port backend are
// buffered in a DEPTH-entry elastic FIFO and replayed on the external read
// interface as: one-cycle o_rd_sop, o_rd_vld words (header first), one-cycle
// o_rd_eop. Header fields of the packet in flight are latched on the header pop.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_xfer_data_vld     backend word valid
//   i_xfer_data[15:0]   backend word (first word of a packet is the header)
//   i_xfer_last         last word of the packet (qualified by i_xfer_data_vld)
//   o_xfer_pause        registered back-pressure to the backend
//   i_rd_ready          external sink can accept words
//   o_rd_sop/o_rd_vld/o_rd_data/o_rd_eop   replayed packet framing and data
//   o_rd_length/o_rd_prior/o_rd_dest_port  header[15:7]/[6:4]/[3:0]
//   o_ovf               sticky overflow (push while full)
//
// state  | meaning
// S_IDLE | waiting for a readable word and sink ready; issues o_rd_sop
// S_SOP  | o_rd_sop cycle; next pop is the header
// S_DATA | popping words while readable and sink ready
// S_EOP  | issues o_rd_eop after the word flagged last
module port_rd_frontend #(
   parameter int DEPTH    = 64,
   parameter int PAUSE_TH = 60,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_xfer_data_vld,
   input  logic [15:0] i_xfer_data,
   input  logic        i_xfer_last,
   output logic        o_xfer_pause,
   input  logic        i_rd_ready,
   output logic        o_rd_sop,
   output logic        o_rd_vld,
   output logic [15:0] o_rd_data,
   output logic        o_rd_eop,
   output logic [8:0]  o_rd_length,
   output logic [2:0]  o_rd_prior,
   output logic [3:0]  o_rd_dest_port,
   output logic        o_ovf
);

   typedef enum logic [1:0] {S_IDLE, S_SOP, S_DATA, S_EOP} state_t;

   localparam logic [AW:0] C_FULL  = (AW+1)'(DEPTH);
   localparam logic [AW:0] C_PAUSE = (AW+1)'(PAUSE_TH);

   logic [16:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_push_d;
   logic          r_first;
   state_t        r_state;

   state_t        w_state_nxt;
   logic          w_push, w_pop, w_first_nxt;
   logic          w_sop_nxt, w_vld_nxt, w_eop_nxt;
   logic [15:0]   w_data_nxt;
   logic [8:0]    w_len_nxt;
   logic [2:0]    w_prior_nxt;
   logic [3:0]    w_dest_nxt;
   logic [AW:0]   w_vis;
   logic [16:0]   w_entry;

   assign w_push  = i_xfer_data_vld && (r_count != C_FULL);
   // The word accepted on the last edge is not yet readable: no bypass path.
   assign w_vis   = r_count - {{AW{1'b0}}, r_push_d};
   assign w_entry = r_mem[r_rd_ptr];

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {i_xfer_last, i_xfer_data};
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_first_nxt = r_first;
      w_sop_nxt   = 1'b0;
      w_vld_nxt   = 1'b0;
      w_eop_nxt   = 1'b0;
      w_data_nxt  = o_rd_data;
      w_len_nxt   = o_rd_length;
      w_prior_nxt = o_rd_prior;
      w_dest_nxt  = o_rd_dest_port;
      case (r_state)
         S_IDLE: begin
            if (w_vis != '0 && i_rd_ready) begin
               w_sop_nxt   = 1'b1;
               w_state_nxt = S_SOP;
            end
         end
         S_SOP: begin
            w_first_nxt = 1'b1;
            w_state_nxt = S_DATA;
         end
         S_DATA: begin
            if (w_vis != '0 && i_rd_ready) begin
               w_pop      = 1'b1;
               w_vld_nxt  = 1'b1;
               w_data_nxt = w_entry[15:0];
               if (r_first) begin
                  w_first_nxt = 1'b0;
                  w_len_nxt   = w_entry[15:7];
                  w_prior_nxt = w_entry[6:4];
                  w_dest_nxt  = w_entry[3:0];
               end
               if (w_entry[16]) w_state_nxt = S_EOP;
            end
         end
         S_EOP: begin
            w_eop_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_push_d       <= 1'b0;
         r_first        <= 1'b0;
         r_state        <= S_IDLE;
         o_xfer_pause   <= 1'b0;
         o_rd_sop       <= 1'b0;
         o_rd_vld       <= 1'b0;
         o_rd_data      <= '0;
         o_rd_eop       <= 1'b0;
         o_rd_length    <= '0;
         o_rd_prior     <= '0;
         o_rd_dest_port <= '0;
         o_ovf          <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
         else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
         r_push_d       <= w_push;
         if (i_xfer_data_vld && !w_push) o_ovf <= 1'b1;
         o_xfer_pause   <= (r_count >= C_PAUSE);
         r_first        <= w_first_nxt;
         r_state        <= w_state_nxt;
         o_rd_sop       <= w_sop_nxt;
         o_rd_vld       <= w_vld_nxt;
         o_rd_data      <= w_data_nxt;
         o_rd_eop       <= w_eop_nxt;
         o_rd_length    <= w_len_nxt;
         o_rd_prior     <= w_prior_nxt;
         o_rd_dest_port <= w_dest_nxt;
      end
   end

endmodule
